// File: rtl/m_axi_stream_pkg.sv
// Shared definitions for the AXI4-Stream transmit path.
//   AXIS_DWIDTH  : default stream / buffer data width in bits (multiple of 8)
//   AXIS_BUFSIZE : default log2 of the transmit buffer depth
//   tx_state_e   : transmitter FSM states, shared so other stream blocks can reuse them
package m_axi_stream_pkg;

    localparam int AXIS_DWIDTH  = 32;
    localparam int AXIS_BUFSIZE = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // buffer accepts writes, waiting for start
        S_SEND = 2'd1,  // streaming buffered words
        S_DONE = 2'd2   // one-cycle completion pulse
    } tx_state_e;

endpackage

// File: rtl/m_axi_stream_buf_ram.sv
// Simple dual-port word buffer behind the stream transmitter (stream_buf_ram role).
//   clk      : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled on the clock edge
//   rdata_o  : registered read data (one-cycle latency)
// A read of the address being written in the same cycle returns the new data,
// so the word at the read address is always current one cycle later.
module m_axi_stream_buf_ram #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rdata_q;

    // NOTE: storage arrays carry no reset so they map onto RAM macros; the
    // pointers in the transmitter decide which contents are meaningful.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/m_axi_stream.sv
// AXI4-Stream master: the core fills a word buffer, pulses start, and the block
// streams exactly the buffered words in write order, tlast on the final beat.
//   clk, xrst          : clock (rising edge) and async active-low reset
//   buf_we, buf_wdata  : core write port, one word per cycle while idle
//   start              : single-cycle pulse, begin streaming buffered words
//   buf_count/buf_full : words currently buffered / buffer holds 2**BUFSIZE words
//   busy, done         : transfer in progress / one-cycle pulse after final beat
//   tvalid/tready/tdata/tstrb/tlast : AXIS master interface (outputs registered)
module m_axi_stream
    import m_axi_stream_pkg::*;
#(
    parameter int DWIDTH  = AXIS_DWIDTH,
    parameter int BUFSIZE = AXIS_BUFSIZE
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                buf_we,
    input  logic [DWIDTH-1:0]   buf_wdata,
    input  logic                start,
    output logic [BUFSIZE:0]    buf_count,
    output logic                buf_full,
    output logic                busy,
    output logic                done,
    output logic                tvalid,
    input  logic                tready,
    output logic [DWIDTH-1:0]   tdata,
    output logic [DWIDTH/8-1:0] tstrb,
    output logic                tlast
);

    typedef logic [BUFSIZE:0]   ptr_t;
    typedef logic [BUFSIZE-1:0] addr_t;

    localparam ptr_t WORDS = ptr_t'(2**BUFSIZE);

    tx_state_e         state_q, state_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DWIDTH-1:0] tdata_q, tdata_d;

    logic              wr_en;
    logic              hs;
    ptr_t              rd_ptr_inc;
    addr_t             raddr;
    logic [DWIDTH-1:0] rdata;

    assign hs         = tvalid_q && tready;
    assign rd_ptr_inc = rd_ptr_q + ptr_t'(1);
    assign buf_full   = (wr_ptr_q == WORDS);
    assign wr_en      = (state_q == S_IDLE) && buf_we && !buf_full && !start;

    m_axi_stream_buf_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (BUFSIZE)
    ) u_buf_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[BUFSIZE-1:0]),
        .wdata_i (buf_wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // The RAM read port runs one word ahead of tdata: while sending, rdata
    // always holds mem[rd_ptr], the next beat, so a handshake can load it at
    // once. Idle keeps address 0 so the first beat is ready when start arrives.
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        raddr    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + ptr_t'(1);
                end
                if (start && (wr_ptr_q != '0)) begin
                    state_d  = S_SEND;
                    tdata_d  = rdata;
                    tvalid_d = 1'b1;
                    tlast_d  = (wr_ptr_q == ptr_t'(1));
                    rd_ptr_d = ptr_t'(1);
                    raddr    = addr_t'(1);
                end
            end

            S_SEND: begin
                raddr = rd_ptr_q[BUFSIZE-1:0];
                if (hs) begin
                    if (tlast_q) begin
                        state_d  = S_DONE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end else begin
                        // Fetch the word after the one being loaded; the top
                        // address wraps harmlessly since it is never sent.
                        raddr    = rd_ptr_inc[BUFSIZE-1:0];
                        tdata_d  = rdata;
                        tlast_d  = (rd_ptr_q == wr_ptr_q - ptr_t'(1));
                        rd_ptr_d = rd_ptr_inc;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
        end
    end

    assign buf_count = wr_ptr_q;
    assign busy      = (state_q == S_SEND);
    assign done      = (state_q == S_DONE);
    assign tvalid    = tvalid_q;
    assign tlast     = tlast_q;
    assign tdata     = tdata_q;
    assign tstrb     = '1;

endmodule

// File: tb/tb_m_axi_stream.sv
// Self-checking bench for m_axi_stream (DWIDTH=32, BUFSIZE=2, WORDS=4).
// A queue-based model tracks which words are buffered and which beats of the
// current packet are still owed; every cycle the DUT outputs are compared to it.
module tb_m_axi_stream;

    localparam int DW    = 32;
    localparam int BS    = 2;
    localparam int WORDS = 2**BS;

    logic          clk = 1'b0;
    logic          xrst = 1'b0;
    logic          buf_we = 1'b0;
    logic [DW-1:0] buf_wdata = '0;
    logic          start = 1'b0;
    logic          tready = 1'b0;
    logic [BS:0]   buf_count;
    logic          buf_full;
    logic          busy;
    logic          done;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tstrb;
    logic          tlast;

    m_axi_stream #(
        .DWIDTH  (DW),
        .BUFSIZE (BS)
    ) dut (
        .clk       (clk),
        .xrst      (xrst),
        .buf_we    (buf_we),
        .buf_wdata (buf_wdata),
        .start     (start),
        .buf_count (buf_count),
        .buf_full  (buf_full),
        .busy      (busy),
        .done      (done),
        .tvalid    (tvalid),
        .tready    (tready),
        .tdata     (tdata),
        .tstrb     (tstrb),
        .tlast     (tlast)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: words accepted into the buffer, beats still owed, and the phase
    // of the transfer (0 = idle, 1 = sending, 2 = completion cycle).
    logic [DW-1:0] model_words[$];
    logic [DW-1:0] exp_q[$];
    int            phase    = 0;
    int            hs_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the model, advance the model over the coming
    // edge using the applied inputs, then move to 1 time unit past that edge.
    task automatic tick();
        check("tvalid", tvalid, phase == 1);
        check("busy", busy, phase == 1);
        check("done", done, phase == 2);
        check("buf_count", buf_count, model_words.size());
        check("buf_full", buf_full, model_words.size() == WORDS);
        if (phase == 1) begin
            check("tdata", tdata, exp_q[0]);
            check("tlast", tlast, exp_q.size() == 1);
        end else begin
            check("tlast_quiet", tlast, 0);
        end

        case (phase)
            0: begin
                if (start && model_words.size() != 0) begin
                    exp_q = model_words;
                    phase = 1;
                end else if (buf_we && !start && model_words.size() < WORDS) begin
                    model_words.push_back(buf_wdata);
                end
            end
            1: begin
                if (tready) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        phase = 2;
                        model_words.delete();
                    end
                end
            end
            default: phase = 0;
        endcase

        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        buf_we    = 1'b1;
        buf_wdata = d;
        tick();
        buf_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until the model is idle again; tready random or held high.
    task automatic drain(input int budget, input bit rnd_ready);
        int n = 0;
        while (phase != 0 && n < budget) begin
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        tready = 1'b1;
        check("drain_in_budget", phase == 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", buf_count, 0);
        check("rst_full", buf_full, 0);
        #16 xrst = 1'b1;
        @(posedge clk);
        #1;

        // 1: three-word packet, back-to-back beats
        tready = 1'b1;
        h0 = hs_count;
        write_word(32'hA0);
        write_word(32'hA1);
        write_word(32'hA2);
        check("tstrb", tstrb, 4'hF);
        pulse_start();
        drain(20, 1'b0);
        check("t1_beats", hs_count - h0, 3);

        // 2: fill to full, fifth write ignored
        h0 = hs_count;
        for (int i = 0; i < 5; i++) write_word(32'h10 + 32'(i));
        check("t2_full", buf_full, 1);
        check("t2_count", buf_count, 4);
        pulse_start();
        drain(20, 1'b0);
        check("t2_beats", hs_count - h0, 4);

        // 3: stalls with a fixed tready pattern
        h0 = hs_count;
        for (int i = 0; i < 3; i++) write_word($urandom);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tready = pat[i];
            tick();
        end
        drain(20, 1'b0);
        check("t3_beats", hs_count - h0, 3);

        // 4: start on empty buffer, then single-word packet
        h0 = hs_count;
        pulse_start();
        tick();
        tick();
        check("t4_empty_beats", hs_count - h0, 0);
        write_word(32'h55);
        pulse_start();
        drain(20, 1'b0);
        check("t4_single_beats", hs_count - h0, 1);

        // 5: write and start during a transfer are ignored
        h0 = hs_count;
        for (int i = 0; i < 4; i++) write_word($urandom);
        pulse_start();
        buf_we    = 1'b1;
        buf_wdata = 32'hDEAD;
        start     = 1'b1;
        tick();
        buf_we = 1'b0;
        start  = 1'b0;
        drain(20, 1'b0);
        check("t5_beats", hs_count - h0, 4);
        check("t5_count", buf_count, 0);

        // 6: asynchronous reset mid-packet, then a clean packet
        for (int i = 0; i < 4; i++) write_word($urandom);
        pulse_start();
        tick();
        tick();
        #2 xrst = 1'b0;
        #1;
        check("arst_tvalid", tvalid, 0);
        check("arst_busy", busy, 0);
        check("arst_count", buf_count, 0);
        phase = 0;
        model_words.delete();
        exp_q.delete();
        @(posedge clk);
        #3 xrst = 1'b1;
        tick();
        tick();
        h0 = hs_count;
        write_word($urandom);
        write_word($urandom);
        pulse_start();
        drain(20, 1'b0);
        check("t6_beats", hs_count - h0, 2);

        // Random packets: random length (may overflow), data and tready
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(1, WORDS + 1);
            for (int i = 0; i < n; i++) write_word($urandom);
            pulse_start();
            drain(200, 1'b1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
